// File: rtl/imgproc_pkg.sv
// rtl/imgproc_pkg.sv - shared state type, width defaults and helpers for the conv2d_stream engine
package imgproc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } conv_state_t;

  localparam int PIX_W   = 8;
  localparam int COEF_W  = 8;
  localparam int MAX_K   = 7;
  localparam int SAT_MIN = 0;

  // Never returns less than 1 so it can size ports for degenerate 1x1 kernels.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 30; i >= 1; i--)
      if ((1 << i) >= v) r = i;
    return r;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/cdm_mult.sv
// rtl/cdm_mult.sv - unsigned pixel x signed coefficient tap multiplier
// APPROX_MUL_EN: carry-disregard variant (partial products XOR-combined on the coefficient magnitude)
module cdm_mult #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic [PW-1:0]  pix,
  input  logic [CW-1:0]  coef,
  output logic [PW+CW:0] prod
);

  localparam int PRW = PW + CW + 1;

`ifdef APPROX_MUL_EN
  logic [CW-1:0]    mag;
  logic [PW+CW-1:0] pp_x;

  always_comb begin
    mag  = coef[CW-1] ? (~coef + CW'(1)) : coef;
    pp_x = '0;
    // Partial products are merged without carry propagation.
    for (int i = 0; i < CW; i++)
      if (mag[i]) pp_x = pp_x ^ ({{CW{1'b0}}, pix} << i);
    prod = coef[CW-1] ? (~{1'b0, pp_x} + PRW'(1)) : {1'b0, pp_x};
  end
`else
  logic [PRW-1:0] a;
  logic [PRW-1:0] b;

  // Low PRW bits of a two's-complement product are independent of operand signedness.
  assign a    = {{(CW + 1){1'b0}}, pix};
  assign b    = {{(PW + 1){coef[CW-1]}}, coef};
  assign prod = a * b;
`endif

endmodule

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK 2-D convolution with zero-padded borders and valid/ready flow
// APPROX_MUL_EN selects the approximate tap multipliers inside cdm_mult; control and latency are unchanged.
module conv2d_stream
  import imgproc_pkg::*;
#(
  parameter int Datawidth = PIX_W,
  parameter int Img_W     = 512,
  parameter int Img_H     = 512,
  parameter int K_W       = 3,
  parameter int K_H       = 3,
  parameter int CoefWidth = COEF_W,
  parameter int Shift     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coef_wr,
  input  logic [clog2(K_W*K_H)-1:0]     coef_addr,
  input  logic [CoefWidth-1:0]          coef_data,
  input  logic [Datawidth-1:0]          in_img_data,
  input  logic                          img_valid,
  output logic                          in_ready,
  output logic [Datawidth-1:0]          out_img_data,
  output logic                          conv_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int KK   = K_W * K_H;
  localparam int RW   = K_W / 2;
  localparam int RH   = K_H / 2;
  localparam int NPIX = Img_W * Img_H;
  localparam int DLY  = RH * Img_W + RW;
  localparam int PCW  = clog2(NPIX + DLY + 1);
  localparam int XW   = clog2(Img_W);
  localparam int YW   = clog2(Img_H);
  localparam int PRW  = Datawidth + CoefWidth + 1;
  localparam int SW   = PRW + clog2(KK);
  localparam int LB   = (K_H > 1) ? K_H - 1 : 1;

  localparam logic [PCW-1:0] IN_LAST   = PCW'(NPIX - 1);
  localparam logic [PCW-1:0] FILL_LAST = PCW'((DLY > 0) ? DLY - 1 : 0);
  localparam logic [PCW-1:0] PUSH_END  = PCW'(NPIX + DLY);
  localparam logic [PCW-1:0] DLY_C     = PCW'(DLY);
  localparam logic [XW-1:0]  X_LAST    = XW'(Img_W - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(Img_H - 1);
  localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(Datawidth));
  localparam logic signed [SW-1:0] SAT_LO = SW'(SAT_MIN);

  conv_state_t          state;
  logic [PCW-1:0]       pcnt;
  logic [PCW-1:0]       ocnt;
  logic [XW-1:0]        lcol;
  logic [XW-1:0]        ox;
  logic [XW-1:0]        win_x;
  logic [YW-1:0]        oy;
  logic [YW-1:0]        win_y;
  logic                 win_vld;
  logic                 p1_vld;
  logic                 p2_vld;
  logic [CoefWidth-1:0] coef [KK];

  logic [Datawidth-1:0] lbuf   [LB][Img_W];
  logic [Datawidth-1:0] win    [K_H][K_W];
  logic [Datawidth-1:0] row_in [K_H];
  logic [Datawidth-1:0] push_pix;
  logic [Datawidth-1:0] tap_pix  [KK];
  logic [PRW-1:0]       tap_prod [KK];
  logic [PRW-1:0]       prod_q   [KK];
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] shifted;
  logic [Datawidth-1:0] sat_d;

  logic stall;
  logic in_xfer;
  logic push;
  logic issue;
  logic out_xfer;

  assign stall    = conv_valid & ~out_ready;
  assign in_ready = reset & ~stall & (state != FLUSH);
  assign in_xfer  = img_valid & in_ready;
  assign push     = in_xfer | ((state == FLUSH) & ~stall & (pcnt < PUSH_END));
  assign push_pix = (state == FLUSH) ? '0 : in_img_data;
  assign issue    = push & (pcnt >= DLY_C);
  assign out_xfer = conv_valid & out_ready;
  assign busy     = (state != IDLE);

  // Row r of the window sees the stream delayed by r lines.
  always_comb begin
    row_in[0] = push_pix;
    for (int r = 1; r < K_H; r++)
      row_in[r] = lbuf[r-1][lcol];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int r = 0; r < K_H - 1; r++)
        lbuf[r][lcol] <= row_in[r];
      for (int r = 0; r < K_H; r++) begin
        win[r][0] <= row_in[r];
        for (int c = 1; c < K_W; c++)
          win[r][c] <= win[r][c-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pcnt    <= '0;
      ocnt    <= '0;
      lcol    <= '0;
      ox      <= '0;
      oy      <= '0;
      win_x   <= '0;
      win_y   <= '0;
      win_vld <= 1'b0;
      for (int k = 0; k < KK; k++)
        coef[k] <= '0;
    end else begin
      if (coef_wr && state == IDLE && int'(coef_addr) < KK)
        coef[coef_addr] <= coef_data;

      if (push) begin
        pcnt <= pcnt + PCW'(1);
        lcol <= (lcol == X_LAST) ? '0 : lcol + XW'(1);
      end

      if (!stall)
        win_vld <= issue;

      if (issue) begin
        win_x <= ox;
        win_y <= oy;
        if (ox == X_LAST) begin
          ox <= '0;
          oy <= (oy == Y_LAST) ? '0 : oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end

      if (out_xfer)
        ocnt <= ocnt + PCW'(1);

      case (state)
        IDLE, FILL, RUN: begin
          if (in_xfer) begin
            if (pcnt == IN_LAST)
              state <= FLUSH;
            else if (pcnt >= FILL_LAST)
              state <= RUN;
            else
              state <= FILL;
          end
        end
        FLUSH: begin
          if (out_xfer && ocnt == IN_LAST) begin
            state <= IDLE;
            pcnt  <= '0;
            ocnt  <= '0;
            lcol  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Taps whose source pixel lies outside the frame read as zero; this also hides stale line data.
  always_comb begin
    for (int k = 0; k < KK; k++) begin
      tap_pix[k] = '0;
      if ((int'(win_y) + k / K_W - RH >= 0) && (int'(win_y) + k / K_W - RH < Img_H) &&
          (int'(win_x) + k % K_W - RW >= 0) && (int'(win_x) + k % K_W - RW < Img_W))
        tap_pix[k] = win[K_H-1-k/K_W][K_W-1-k%K_W];
    end
  end

  for (genvar k = 0; k < KK; k++) begin : g_tap
    cdm_mult #(
      .PW (Datawidth),
      .CW (CoefWidth)
    ) u_mult (
      .pix  (tap_pix[k]),
      .coef (coef[k]),
      .prod (tap_prod[k])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < KK; k++)
      sum_d = sum_d + SW'($signed(prod_q[k]));
  end

  assign shifted = sum_q >>> Shift;

  always_comb begin
    if (shifted < SAT_LO)
      sat_d = '0;
    else if (shifted > SAT_HI)
      sat_d = '1;
    else
      sat_d = shifted[Datawidth-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_vld       <= 1'b0;
      p2_vld       <= 1'b0;
      conv_valid   <= 1'b0;
      out_img_data <= '0;
      sum_q        <= '0;
      for (int k = 0; k < KK; k++)
        prod_q[k] <= '0;
    end else if (!stall) begin
      p1_vld     <= win_vld;
      p2_vld     <= p1_vld;
      conv_valid <= p2_vld;
      for (int k = 0; k < KK; k++)
        prod_q[k] <= tap_prod[k];
      sum_q <= sum_d;
      if (p2_vld)
        out_img_data <= sat_d;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb/tb_conv2d_stream.sv - self-checking bench for conv2d_stream (8x8 frames, 3x3 kernel, Shift 0 and 3)
module tb_conv2d_stream;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;
  localparam int DLY  = W + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       coef_wr;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic [7:0] in_img_data;
  logic       img_valid;
  logic       out_ready;
  logic       in_ready0, conv_valid0, busy0;
  logic       in_ready3, conv_valid3, busy3;
  logic [7:0] out0, out3;

  conv2d_stream #(.Datawidth(8), .Img_W(W), .Img_H(H), .K_W(3), .K_H(3), .CoefWidth(8), .Shift(0)) dut0 (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_img_data(in_img_data), .img_valid(img_valid), .in_ready(in_ready0),
    .out_img_data(out0), .conv_valid(conv_valid0), .out_ready(out_ready), .busy(busy0));

  conv2d_stream #(.Datawidth(8), .Img_W(W), .Img_H(H), .K_W(3), .K_H(3), .CoefWidth(8), .Shift(3)) dut3 (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_img_data(in_img_data), .img_valid(img_valid), .in_ready(in_ready3),
    .out_img_data(out3), .conv_valid(conv_valid3), .out_ready(out_ready), .busy(busy3));

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cval;
    bit    all;
    int    pix;
    bit    s3;
    int    e_int;
    int    e_edge;
    int    e_corner;
  } vec_t;

  vec_t tbl [6];
  int   img  [NPIX];
  int   cf   [9];
  int   exp0 [NPIX];
  int   exp3 [NPIX];
  int   got0 [NPIX];
  int   got3 [NPIX];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  function automatic int mul_ref(input int p, input int c);
`ifdef APPROX_MUL_EN
    int m, acc;
    m   = (c < 0) ? -c : c;
    acc = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) acc = acc ^ (p << i);
    return (c < 0) ? -acc : acc;
`else
    return p * c;
`endif
  endfunction

  // Direct definition: zero-padded 3x3 correlation, arithmetic shift, clamp to 0..255.
  function automatic int ref_pix(input int y, input int x, input int sh);
    int s;
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (y + dy >= 0 && y + dy < H && x + dx >= 0 && x + dx < W)
          s += mul_ref(img[(y + dy) * W + x + dx], cf[(dy + 1) * 3 + dx + 1]);
    s = s >>> sh;
    return (s < 0) ? 0 : (s > 255) ? 255 : s;
  endfunction

  task automatic build_expected();
    for (int i = 0; i < NPIX; i++) begin
      exp0[i] = ref_pix(i / W, i % W, 0);
      exp3[i] = ref_pix(i / W, i % W, 3);
    end
  endtask

  task automatic load_coefs();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_wr   = 1'b1;
      coef_addr = 4'(i);
      coef_data = 8'(cf[i]);
    end
    @(negedge clk);
    coef_wr = 1'b0;
  endtask

  task automatic run_frame(input string nm, input bit rnd, input bit busy_wr);
    int idx, n0, n3, cyc, xfer_c, first_c, bad0, bad3;
    idx = 0; n0 = 0; n3 = 0; cyc = 0; xfer_c = -1; first_c = -1;
    while ((idx < NPIX || n0 < NPIX || n3 < NPIX) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (idx < NPIX && (!rnd || $urandom_range(0, 3) != 0)) begin
        img_valid   = 1'b1;
        in_img_data = 8'(img[idx]);
      end else begin
        img_valid   = 1'b0;
        in_img_data = '0;
      end
      coef_wr   = busy_wr && (idx == 5);
      coef_addr = 4'd4;
      coef_data = 8'd7;
      #1;
      if (img_valid && in_ready0) begin
        if (idx == DLY) xfer_c = cyc;
        idx++;
      end
      if (conv_valid0 && first_c < 0) first_c = cyc;
      if (conv_valid0 && out_ready) begin
        if (n0 < NPIX) got0[n0] = out0;
        n0++;
      end
      if (conv_valid3 && out_ready) begin
        if (n3 < NPIX) got3[n3] = out3;
        n3++;
      end
    end
    img_valid = 1'b0;
    coef_wr   = 1'b0;
    repeat (6) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (conv_valid0) n0++;
      if (conv_valid3) n3++;
    end
    bad0 = 0; bad3 = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i < n0 && got0[i] != exp0[i]) bad0++;
      if (i < n3 && got3[i] != exp3[i]) bad3++;
    end
    check({nm, " count_s0"}, n0, NPIX);
    check({nm, " count_s3"}, n3, NPIX);
    check({nm, " stream_s0 mismatches"}, bad0, 0);
    check({nm, " stream_s3 mismatches"}, bad3, 0);
    check({nm, " busy after frame"}, int'(busy0), 0);
    // The issuing edge follows sample xfer_c; conv_valid must be registered 3 edges later.
    if (!rnd) check({nm, " first-output latency"}, first_c - (xfer_c + 1), 3);
  endtask

  task automatic set_row(input int i, input string n, input int cval, input bit all, input int pix,
                         input bit s3, input int ei, input int ee, input int ec);
    tbl[i].name = n; tbl[i].cval = cval; tbl[i].all = all; tbl[i].pix = pix;
    tbl[i].s3 = s3; tbl[i].e_int = ei; tbl[i].e_edge = ee; tbl[i].e_corner = ec;
  endtask

  function automatic int pick(input bit s3, input int i);
    return s3 ? got3[i] : got0[i];
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 9; i++) cf[i] = (i == 4) ? 1 : 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, cyc, bad;

    set_row(0, "ones_s3_80",      1, 1'b1,  80, 1'b1,  90,  60,  40);
    set_row(1, "ones_s0_10",      1, 1'b1,  10, 1'b0,  90,  60,  40);
    set_row(2, "ones_s3_200",     1, 1'b1, 200, 1'b1, 225, 150, 100);
    set_row(3, "center4_sat_hi",  4, 1'b0, 100, 1'b0, 255, 255, 255);
    set_row(4, "centerm1_sat_lo", -1, 1'b0, 100, 1'b0,  0,   0,   0);
    set_row(5, "ones_s0_sat",     1, 1'b1, 100, 1'b0, 255, 255, 255);

    reset = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    in_img_data = '0; img_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset conv_valid", int'(conv_valid0), 0);
    check("reset out_img_data", int'(out0), 0);
    check("reset busy", int'(busy0), 0);
    check("reset in_ready", int'(in_ready0), 0);
    reset = 1'b1;
    @(negedge clk);

    // Identity kernel over a ramp, with an ignored coefficient write mid-frame.
    set_identity();
    for (int i = 0; i < NPIX; i++) img[i] = i;
    build_expected();
    load_coefs();
    run_frame("identity_ramp", 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (got0[i] != i) bad++;
    check("identity_ramp outputs != index", bad, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 9; i++) cf[i] = (tbl[t].all || i == 4) ? tbl[t].cval : 0;
      for (int i = 0; i < NPIX; i++) img[i] = tbl[t].pix;
      build_expected();
      load_coefs();
      run_frame(tbl[t].name, t[0], 1'b0);
      check({tbl[t].name, " interior(3,3)"}, pick(tbl[t].s3, 3 * W + 3), tbl[t].e_int);
      check({tbl[t].name, " edge(0,3)"}, pick(tbl[t].s3, 3), tbl[t].e_edge);
      check({tbl[t].name, " corner(0,0)"}, pick(tbl[t].s3, 0), tbl[t].e_corner);
    end

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 9; i++)
        cf[i] = (f == 2) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
      for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
      build_expected();
      load_coefs();
      run_frame($sformatf("random_%0d", f), 1'b1, 1'b0);
    end

    // Reset pulled low after 30 pixels of a frame.
    set_identity();
    for (int i = 0; i < NPIX; i++) img[i] = i;
    load_coefs();
    idx = 0; cyc = 0;
    while (idx < 30 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      img_valid = 1'b1; in_img_data = 8'(idx); out_ready = 1'b1;
      #1;
      if (in_ready0) idx++;
    end
    @(negedge clk);
    img_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midframe reset conv_valid", int'(conv_valid0), 0);
    check("midframe reset busy", int'(busy0), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) cf[i] = 0;
    build_expected();
    run_frame("after_reset_coefs_cleared", 1'b1, 1'b0);

    set_identity();
    build_expected();
    load_coefs();
    run_frame("frame2_reloaded", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
